// File: rtl/column_coeff_sequencer_if.sv
// Pixel stream, line configuration and coefficient-write bus for
// column_coeff_sequencer.
//   master : drives data_i/valid_i/sol_i, line_width_i, bypass_i, coef_*;
//            observes data_o/sigma_o/delta_o/valid_o/col_o/overrun_o
//   slave  : the sequencer side (directions reversed)
interface column_coeff_sequencer_if #(
  parameter int DATA_BITS  = 8,
  parameter int SIGMA_BITS = 8,
  parameter int DELTA_BITS = 8,
  parameter int COL_BITS   = 12
);
  logic [DATA_BITS-1:0]  data_i;
  logic                  valid_i;
  logic                  sol_i;
  logic [COL_BITS-1:0]   line_width_i;
  logic                  bypass_i;
  logic                  coef_we_i;
  logic [COL_BITS-1:0]   coef_addr_i;
  logic [SIGMA_BITS-1:0] coef_sigma_i;
  logic [DELTA_BITS-1:0] coef_delta_i;

  logic [DATA_BITS-1:0]  data_o;
  logic [SIGMA_BITS-1:0] sigma_o;
  logic [DELTA_BITS-1:0] delta_o;
  logic                  valid_o;
  logic [COL_BITS-1:0]   col_o;
  logic                  overrun_o;

  modport master (
    output data_i, valid_i, sol_i, line_width_i, bypass_i,
           coef_we_i, coef_addr_i, coef_sigma_i, coef_delta_i,
    input  data_o, sigma_o, delta_o, valid_o, col_o, overrun_o
  );

  modport slave (
    input  data_i, valid_i, sol_i, line_width_i, bypass_i,
           coef_we_i, coef_addr_i, coef_sigma_i, coef_delta_i,
    output data_o, sigma_o, delta_o, valid_o, col_o, overrun_o
  );
endinterface

// File: rtl/column_coeff_sequencer.sv
// Column coefficient sequencer: tags each incoming pixel with its column
// index and the {sigma, delta} correction coefficients stored for that
// column, with a fixed two-cycle latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (coefficient RAM is not reset)
//   bus   : slave side of column_coeff_sequencer_if
//           inputs  data_i, valid_i, sol_i, line_width_i (0 = 2**COL_BITS),
//                   bypass_i, coef_we_i/coef_addr_i/coef_sigma_i/coef_delta_i
//           outputs data_o, sigma_o, delta_o, valid_o, col_o, overrun_o
module column_coeff_sequencer #(
  parameter int DATA_BITS       = 8,
  parameter int SIGMA_BITS      = 8,
  parameter int SIGMA_FRAC_BITS = 7,
  parameter int DELTA_BITS      = 8,
  parameter int COL_BITS        = 12
) (
  input logic clk,
  input logic rst_n,
  column_coeff_sequencer_if.slave bus
);

  localparam int COEF_BITS = SIGMA_BITS + DELTA_BITS;
  localparam logic [SIGMA_BITS-1:0] UNITY = SIGMA_BITS'(1) << SIGMA_FRAC_BITS;
  // Pixel index one wider than a column: value 2**COL_BITS marks "past the
  // last addressable column", so saturated pixels are always out of line.
  localparam logic [COL_BITS:0] IDX_SAT = {1'b1, {COL_BITS{1'b0}}};

  // Column tracking state
  logic [COL_BITS:0]   cnt_q, cnt_d;
  logic [COL_BITS-1:0] width_q, width_d;
  logic                started_q, started_d;

  // Stage 1 (N+1)
  logic                 s1_valid_q;
  logic [DATA_BITS-1:0] s1_data_q;
  logic [COL_BITS-1:0]  s1_col_q;
  logic                 s1_unity_q;
  logic                 s1_oor_q;
  logic [COEF_BITS-1:0] rd_q;

  // Stage 2 (N+2) / outputs
  logic                  valid_o_q;
  logic [DATA_BITS-1:0]  data_o_q;
  logic [SIGMA_BITS-1:0] sigma_o_q;
  logic [DELTA_BITS-1:0] delta_o_q;
  logic [COL_BITS-1:0]   col_o_q;
  logic                  overrun_q;

  logic [COEF_BITS-1:0] mem [2**COL_BITS];

  logic [COL_BITS:0]   width_eff;
  logic [COL_BITS-1:0] pix_col;
  logic                pix_inline;
  logic [COL_BITS-1:0] out_col;

  always_comb begin
    width_eff = (width_q == '0) ? IDX_SAT : {1'b0, width_q};
    if (bus.sol_i) begin
      // Column 0 is inside every line since widths are at least 1.
      pix_col    = '0;
      pix_inline = 1'b1;
    end else begin
      pix_col    = cnt_q[COL_BITS] ? '1 : cnt_q[COL_BITS-1:0];
      pix_inline = started_q && (cnt_q < width_eff);
    end
    // width-1 in COL_BITS arithmetic also yields MAX_COLS-1 for width 0
    out_col = pix_inline ? pix_col : (width_q - 1'b1);
  end

  always_comb begin
    cnt_d     = cnt_q;
    width_d   = width_q;
    started_d = started_q;
    if (bus.valid_i) begin
      if (bus.sol_i) begin
        cnt_d     = {{COL_BITS{1'b0}}, 1'b1};
        width_d   = bus.line_width_i;
        started_d = 1'b1;
      end else if (cnt_q != IDX_SAT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      width_q   <= '0;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      started_q <= started_d;
    end
  end

  // Read-first RAM: a same-cycle write is not visible to this read.
  always_ff @(posedge clk) begin
    if (bus.coef_we_i) begin
      mem[bus.coef_addr_i] <= {bus.coef_sigma_i, bus.coef_delta_i};
    end
    rd_q <= mem[pix_col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_col_q   <= '0;
      s1_unity_q <= 1'b0;
      s1_oor_q   <= 1'b0;
    end else begin
      s1_valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        s1_data_q  <= bus.data_i;
        s1_col_q   <= out_col;
        s1_unity_q <= bus.bypass_i || !pix_inline;
        s1_oor_q   <= !pix_inline;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o_q <= 1'b0;
      data_o_q  <= '0;
      sigma_o_q <= '0;
      delta_o_q <= '0;
      col_o_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_o_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_o_q  <= s1_data_q;
        col_o_q   <= s1_col_q;
        sigma_o_q <= s1_unity_q ? UNITY : rd_q[COEF_BITS-1:DELTA_BITS];
        delta_o_q <= s1_unity_q ? '0 : rd_q[DELTA_BITS-1:0];
        if (s1_oor_q) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign bus.valid_o   = valid_o_q;
  assign bus.data_o    = data_o_q;
  assign bus.sigma_o   = sigma_o_q;
  assign bus.delta_o   = delta_o_q;
  assign bus.col_o     = col_o_q;
  assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_column_coeff_sequencer.sv
// Self-checking bench for column_coeff_sequencer: directed scenarios plus a
// randomized run, all compared against a line/pixel-count reference model.
module tb_column_coeff_sequencer;

  localparam int MAXC = 4096;

  typedef struct packed {
    logic       v;
    logic [7:0] data;
    logic [11:0] col;
    logic [7:0] sig;
    logic [7:0] del;
    logic       oor;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   nerr  = 0;
  int   nchk  = 0;

  column_coeff_sequencer_if #(.DATA_BITS(8), .SIGMA_BITS(8), .DELTA_BITS(8), .COL_BITS(12)) bus();

  column_coeff_sequencer #(
    .DATA_BITS(8), .SIGMA_BITS(8), .SIGMA_FRAC_BITS(7), .DELTA_BITS(8), .COL_BITS(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: coefficient table, line state, two-deep output pipe.
  logic [15:0] mmem [16];
  bit   mstarted;
  int   mwidth;
  int   midx;
  exp_t p1, mout;
  bit   mvalid, movr;

  function automatic void model_reset();
    mstarted = 0; mwidth = MAXC; midx = 0;
    p1 = '0; mout = '0; mvalid = 0; movr = 0;
  endfunction

  task automatic cyc(input bit v, input bit s, input logic [7:0] d, input logic [11:0] w,
                     input bit byp, input bit we, input int wa, input logic [7:0] ws,
                     input logic [7:0] wd, output exp_t e);
    exp_t n;
    int   idx;
    bit   inl;
    bus.valid_i = v; bus.sol_i = s; bus.data_i = d; bus.line_width_i = w;
    bus.bypass_i = byp; bus.coef_we_i = we; bus.coef_addr_i = 12'(wa);
    bus.coef_sigma_i = ws; bus.coef_delta_i = wd;
    n = '0;
    n.v = v;
    if (v) begin
      if (s) begin
        mstarted = 1; mwidth = (w == 0) ? MAXC : int'(w); midx = 0;
      end
      idx = midx;
      midx++;
      inl = mstarted && (idx < mwidth);
      n.data = d;
      n.col  = inl ? 12'(idx) : 12'(mwidth - 1);
      if (inl && !byp && idx < 16) {n.sig, n.del} = mmem[idx];
      else begin n.sig = 8'd128; n.del = 8'd0; end
      n.oor = !inl;
    end
    if (p1.v) begin
      mout = p1;
      if (p1.oor) movr = 1;
    end
    mvalid = p1.v;
    p1 = n;
    if (we && wa < 16) mmem[wa] = {ws, wd};
    @(posedge clk);
    #1;
    e = mout;
    e.v = mvalid;
    e.oor = movr;
  endtask

  task automatic do_reset();
    bus.valid_i = 0; bus.sol_i = 0; bus.coef_we_i = 0; bus.bypass_i = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    nchk++;
    if ({bus.valid_o, bus.data_o, bus.sigma_o, bus.delta_o, bus.col_o, bus.overrun_o} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got v=%b d=%h s=%h dl=%h c=%0d o=%b required all zero",
               bus.valid_o, bus.data_o, bus.sigma_o, bus.delta_o, bus.col_o, bus.overrun_o);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    // load coefficients: cols 0..7 fixed pattern, 8..15 random
    for (int c = 0; c < 16; c++) begin
      logic [7:0] s8, d8;
      s8 = (c < 8) ? 8'(c + 64) : 8'($urandom);
      d8 = (c < 8) ? 8'(c - 2) : 8'($urandom);
      cyc(0, 0, 0, 8, 0, 1, c, s8, d8, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL reset_idle valid_o got=%b exp=%b", bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o} !== '0) begin
        nerr++; $display("FAIL reset_idle outputs got d=%h c=%0d s=%h dl=%h o=%b exp zero",
                         bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o);
      end
    end
  endtask

  task automatic test_contiguous();
    exp_t e;
    int   k = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(i < 8, i == 0, 8'($urandom), 12'd8, 0, 0, 0, 0, 0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL contig valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o} !== {e.data, e.col, e.sig, e.del}) begin
        nerr++; $display("FAIL contig out i=%0d got=%h/%0d/%0d/%h exp=%h/%0d/%0d/%h", i, bus.data_o, bus.col_o,
                         bus.sigma_o, bus.delta_o, e.data, e.col, e.sig, e.del);
      end
      nchk++;
      if (bus.overrun_o !== 1'b0) begin nerr++; $display("FAIL contig overrun got=%b exp=0", bus.overrun_o); end
      if (e.v) begin
        nchk++;
        if (bus.col_o !== 12'(k) || bus.sigma_o !== 8'(64 + k) || bus.delta_o !== 8'(k - 2)) begin
          nerr++; $display("FAIL contig table k=%0d got col=%0d sig=%0d del=%0d", k, bus.col_o, bus.sigma_o, $signed(bus.delta_o));
        end
        k++;
      end
    end
    nchk++;
    if (k !== 8) begin nerr++; $display("FAIL contig count got=%0d exp=8", k); end
  endtask

  task automatic test_gaps();
    exp_t e;
    int   sent = 0, k = 0, gap = 0;
    for (int i = 0; i < 60 && (sent < 8 || i < sent + 40); i++) begin
      bit v;
      v = (gap == 0) && (sent < 8);
      if (v) begin gap = $urandom_range(1, 3); sent++; end else if (gap > 0) gap--;
      // sol without valid must be ignored
      cyc(v, v ? (sent == 1) : ($urandom_range(0, 1) == 1), 8'($urandom), 12'd8, 0, 0, 0, 0, 0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL gaps valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o} !== {e.data, e.col, e.sig, e.del, e.oor}) begin
        nerr++; $display("FAIL gaps out i=%0d got=%h/%0d/%0d/%h/%b exp=%h/%0d/%0d/%h/%b", i, bus.data_o, bus.col_o,
                         bus.sigma_o, bus.delta_o, bus.overrun_o, e.data, e.col, e.sig, e.del, e.oor);
      end
      if (e.v) begin
        nchk++;
        if (bus.col_o !== 12'(k) || bus.sigma_o !== 8'(64 + k)) begin
          nerr++; $display("FAIL gaps table k=%0d got col=%0d sig=%0d", k, bus.col_o, bus.sigma_o);
        end
        k++;
      end
      if (sent == 8 && gap == 0 && i > 30) break;
    end
    nchk++;
    if (k !== 8) begin nerr++; $display("FAIL gaps count got=%0d exp=8", k); end
  endtask

  task automatic test_collision();
    exp_t e;
    int   k = 0;
    for (int i = 0; i < 22; i++) begin
      int p;
      p = (i < 11) ? i : i - 11;
      // write col 2 in the same cycle the first line's col-2 pixel is issued
      cyc(p < 8, p == 0, 8'($urandom), 12'd8, 0, i == 2, 2, 8'd200, 8'd0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL collide valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o} !== {e.data, e.col, e.sig, e.del, e.oor}) begin
        nerr++; $display("FAIL collide out i=%0d got=%h/%0d/%0d/%h exp=%h/%0d/%0d/%h", i, bus.data_o, bus.col_o,
                         bus.sigma_o, bus.delta_o, e.data, e.col, e.sig, e.del);
      end
      if (e.v && bus.col_o == 12'd2) begin
        nchk++;
        if (bus.sigma_o !== ((k == 0) ? 8'd66 : 8'd200)) begin
          nerr++; $display("FAIL collide col2 line=%0d got sig=%0d exp=%0d", k, bus.sigma_o, (k == 0) ? 66 : 200);
        end
        k++;
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    int   k = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(i < 8, i == 0, 8'($urandom), 12'd8, 1, 0, 0, 0, 0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL bypass valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      if (e.v) begin
        nchk++;
        if (bus.col_o !== 12'(k) || bus.sigma_o !== 8'd128 || bus.delta_o !== 8'd0 || bus.data_o !== e.data) begin
          nerr++; $display("FAIL bypass out k=%0d got col=%0d sig=%0d del=%0d exp col=%0d sig=128 del=0",
                           k, bus.col_o, bus.sigma_o, bus.delta_o, k);
        end
        k++;
      end
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    int   k = 0;
    // width 4 with 6 pixels, then a good width-8 line
    for (int i = 0; i < 20; i++) begin
      bit v, s;
      v = (i < 6) || (i >= 8 && i < 16);
      s = (i == 0) || (i == 8);
      cyc(v, s, 8'($urandom), (i < 8) ? 12'd4 : 12'd8, 0, 0, 0, 0, 0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL overrun valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o} !== {e.data, e.col, e.sig, e.del, e.oor}) begin
        nerr++; $display("FAIL overrun out i=%0d got=%h/%0d/%0d/%h/%b exp=%h/%0d/%0d/%h/%b", i, bus.data_o, bus.col_o,
                         bus.sigma_o, bus.delta_o, bus.overrun_o, e.data, e.col, e.sig, e.del, e.oor);
      end
      if (e.v) begin
        if (k == 4 || k == 5) begin
          nchk++;
          if (bus.col_o !== 12'd3 || bus.sigma_o !== 8'd128 || bus.delta_o !== 8'd0) begin
            nerr++; $display("FAIL overrun sat k=%0d got col=%0d sig=%0d del=%0d exp col=3 sig=128 del=0",
                             k, bus.col_o, bus.sigma_o, bus.delta_o);
          end
        end
        k++;
      end
    end
    nchk++;
    if (bus.overrun_o !== 1'b1) begin nerr++; $display("FAIL overrun sticky got=%b exp=1", bus.overrun_o); end
  endtask

  task automatic test_width_zero();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      cyc(i < 5, i == 0, 8'($urandom), 12'd0, 0, 0, 0, 0, 0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL wzero valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o} !== {e.data, e.col, e.sig, e.del, e.oor}) begin
        nerr++; $display("FAIL wzero out i=%0d got=%h/%0d/%0d/%h exp=%h/%0d/%0d/%h", i, bus.data_o, bus.col_o,
                         bus.sigma_o, bus.delta_o, e.data, e.col, e.sig, e.del);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   left = 0;
    logic [11:0] w = 12'd8;
    for (int i = 0; i < 400; i++) begin
      bit v, s;
      v = ($urandom_range(0, 2) != 0) && (i < 395);
      s = 0;
      if (v) begin
        if (left == 0) begin s = 1; w = 12'($urandom_range(1, 16)); left = $urandom_range(1, int'(w) + 3); end
        left--;
      end else s = ($urandom_range(0, 3) == 0);
      cyc(v, s, 8'($urandom), w, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 15), 8'($urandom), 8'($urandom), e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL random valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o} !== {e.data, e.col, e.sig, e.del, e.oor}) begin
        nerr++; $display("FAIL random out i=%0d got=%h/%0d/%0d/%h/%b exp=%h/%0d/%0d/%h/%b", i, bus.data_o, bus.col_o,
                         bus.sigma_o, bus.delta_o, bus.overrun_o, e.data, e.col, e.sig, e.del, e.oor);
      end
    end
  endtask

  task automatic test_midline_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) cyc(1, i == 0, 8'($urandom), 12'd8, 0, 0, 0, 0, 0, e);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(i >= 4 && i < 12, i == 4, 8'($urandom), 12'd12, 0, 0, 0, 0, 0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL midreset valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      nchk++;
      if ({bus.data_o, bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o} !== {e.data, e.col, e.sig, e.del, e.oor}) begin
        nerr++; $display("FAIL midreset out i=%0d got=%h/%0d/%0d/%h/%b exp=%h/%0d/%0d/%h/%b", i, bus.data_o, bus.col_o,
                         bus.sigma_o, bus.delta_o, bus.overrun_o, e.data, e.col, e.sig, e.del, e.oor);
      end
    end
  endtask

  task automatic test_presol();
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(i < 3, 0, 8'($urandom), 12'd8, 0, 0, 0, 0, 0, e);
      nchk++;
      if (bus.valid_o !== e.v) begin nerr++; $display("FAIL presol valid_o i=%0d got=%b exp=%b", i, bus.valid_o, e.v); end
      if (e.v) begin
        nchk++;
        if (bus.col_o !== 12'd4095 || bus.sigma_o !== 8'd128 || bus.delta_o !== 8'd0 || bus.overrun_o !== 1'b1) begin
          nerr++; $display("FAIL presol out got col=%0d sig=%0d del=%0d ovr=%b exp col=4095 sig=128 del=0 ovr=1",
                           bus.col_o, bus.sigma_o, bus.delta_o, bus.overrun_o);
        end
      end
    end
  endtask

  initial begin
    bus.valid_i = 0; bus.sol_i = 0; bus.data_i = '0; bus.line_width_i = '0; bus.bypass_i = 0;
    bus.coef_we_i = 0; bus.coef_addr_i = '0; bus.coef_sigma_i = '0; bus.coef_delta_i = '0;
    model_reset();
    #2;
    test_reset();
    test_contiguous();
    test_gaps();
    test_collision();
    test_bypass();
    test_overrun();
    test_width_zero();
    test_random();
    test_midline_reset();
    test_presol();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
